replace_event_queue: RTL and testbench
======================================

# replace_event_queue

Downstream stage of the Replace Order ('U') decoder. It holds each one-cycle `replace_internal_valid` result in a staging register for one cycle so that a trailing `replace_packet_invalid` (overrun) can cancel it. Surviving messages are committed to a first-word-fall-through FIFO and presented to the order-book update logic over a valid/ready handshake. Cancelled and overflowed messages are counted.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `CNT_W`, 16, width of the drop counters
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  reset; synchronous, active-high
- `replace_internal_valid`  in  1  decoder one-cycle "message parsed" pulse
- `replace_packet_invalid`  in  1  decoder overrun/truncation flag
- `replace_parsed_type`  in  8  parsed type (0x55)
- `replace_old_order_ref`  in  64  original order reference
- `replace_new_order_ref`  in  64  new order reference
- `replace_shares`  in  32  updated shares
- `replace_price`  in  32  updated price
- `out_valid`  out  1  head entry available
- `out_ready`  in  1  consumer accepts head
- `out_parsed_type`, `out_old_order_ref`, `out_new_order_ref`, `out_shares`, `out_price`  out  8/64/64/32/32  head entry fields
- `fifo_count`  out  $clog2(DEPTH)+1  committed entries held
- `fifo_full`  out  1  `fifo_count == DEPTH`
- `cancel_count`  out  CNT_W  staged messages cancelled by `replace_packet_invalid`
- `overflow_count`  out  CNT_W  messages dropped because the FIFO was full

## Operation
- Staging:
  - A `replace_internal_valid` sampled high captures all five fields into the stage and sets `stage_valid`.
- Resolve:
  - In every cycle with `stage_valid`=1, the stage resolves at the next edge.
  - If `replace_packet_invalid`=1, the stage is discarded and `cancel_count`++.
  - Otherwise the stage is pushed to the FIFO.
  - If the FIFO is full with no same-cycle pop, the push is dropped and `overflow_count`++.
- Same-cycle events:
  - A new `replace_internal_valid` in a resolve cycle: the old stage resolves using that cycle's `replace_packet_invalid`, and the new message is captured in the same edge. `stage_valid` stays 1.
  - `replace_packet_invalid` with `stage_valid`=0 is ignored. This covers mid-message `valid_in` loss, where no pulse preceded it.
- FIFO:
  - First-word-fall-through; `out_valid` = !empty.
  - Pop on `out_valid && out_ready`.
  - Push and pop in the same cycle while full: the push is accepted and `fifo_count` is unchanged.
  - Push and pop in the same cycle while empty is impossible, because the head appears only after commit.
- Output fields are driven to 0 whenever `out_valid`=0.
- Counters saturate at all-ones and never wrap.
- Pointers wrap modulo DEPTH and carry an extra bit to distinguish full from empty.

## Timing
- Reset values: all outputs 0, `stage_valid` 0, pointers 0, counters 0.
- Reset mid-operation discards the stage and all FIFO contents. It does not increment counters.
- Latency into an empty FIFO: pulse in cycle T → captured at end of T → resolved at end of T+1 → `out_valid`=1 in cycle T+2.
- `out_valid` is held with stable data until accepted. `out_ready` may toggle freely and is not required to be asserted before `out_valid`.
- `fifo_count`, `fifo_full` and both counters are registered. They reflect the state after the most recent edge.
- Throughput: one commit and one pop per cycle.

## Structure
- Shared package `itch_pkg`:
  - `replace_event_t` packed struct {`parsed_type`, `old_ref`, `new_ref`, `shares`, `price`}.
  - `REPLACE_EVENT_W` = 200.
  - `MSG_TYPE_REPLACE` = 8'h55.
- Sub-module `itch_sync_fifo` (params `WIDTH`, `DEPTH`):
  - Generic FWFT FIFO with push/pop/full/empty/count.
  - Reused by the other message queues.
- The top level contains the stage register, the resolve logic and the saturating counters.

## Test plan
- Single message: old=0x1122334455667788, new=0x99AABBCCDDEEFF00, shares=100, price=0x00012345, `out_ready`=1 → `out_valid` is high exactly in cycle T+2 with identical fields, then `fifo_count` returns to 0.
- Cancel: pulse at T, `replace_packet_invalid` at T+1 → no `out_valid`, `cancel_count`=1, `fifo_count`=0.
- Overflow: `out_ready`=0, DEPTH+2 messages spaced 27 cycles apart → `fifo_full`=1, `overflow_count`=2. Draining yields the first DEPTH messages in order.
- Full push/pop: FIFO full and `out_ready`=1 in a resolve cycle → new entry accepted, `fifo_count` stays DEPTH, `overflow_count` unchanged.
- Back-to-back: pulses at T and T+1, with `replace_packet_invalid` at T+1 and T+2 low → first message cancelled, second delivered. Separately, `replace_packet_invalid` with no pulse → no counter change.
- Reset mid-operation: `rst` asserted with 3 entries queued and the stage full → all outputs 0 next cycle. Counter saturation is checked with `CNT_W`=2: 5 cancels → `cancel_count`=3.

Source files
------------

// File: rtl/itch_pkg.sv
// Shared ITCH message-queue types: the Replace Order event record and its message type code.
package itch_pkg;

    localparam int REPLACE_EVENT_W = 200;
    localparam logic [7:0] MSG_TYPE_REPLACE = 8'h55;

    typedef struct packed {
        logic [7:0]  parsed_type;
        logic [63:0] old_ref;
        logic [63:0] new_ref;
        logic [31:0] shares;
        logic [31:0] price;
    } replace_event_t;

endpackage

// File: rtl/itch_sync_fifo.sv
// Generic first-word-fall-through FIFO shared by the ITCH message queues.
// The head entry is visible combinationally whenever the FIFO is not empty.
module itch_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot in the same edge, so a push while full is accepted alongside it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (wr_ptr == rd_ptr);
    assign head_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/replace_event_queue.sv
// Replace Order event queue: one-cycle staging so a trailing overrun can cancel a parsed
// message, then commit into a FWFT FIFO with saturating cancel/overflow counters.
module replace_event_queue
    import itch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       replace_internal_valid,
    input  logic                       replace_packet_invalid,
    input  logic [7:0]                 replace_parsed_type,
    input  logic [63:0]                replace_old_order_ref,
    input  logic [63:0]                replace_new_order_ref,
    input  logic [31:0]                replace_shares,
    input  logic [31:0]                replace_price,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_parsed_type,
    output logic [63:0]                out_old_order_ref,
    output logic [63:0]                out_new_order_ref,
    output logic [31:0]                out_shares,
    output logic [31:0]                out_price,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       fifo_full,
    output logic [CNT_W-1:0]           cancel_count,
    output logic [CNT_W-1:0]           overflow_count
);

    replace_event_t in_event;
    replace_event_t stage_data;
    replace_event_t head;
    logic           stage_valid;
    logic           pop;
    logic           empty;
    logic           cancel;
    logic           commit;
    logic           overflow;

    assign in_event = {replace_parsed_type, replace_old_order_ref, replace_new_order_ref,
                       replace_shares, replace_price};

    // Output handshake: the head transfers on a cycle where out_valid && out_ready; out_valid
    // and the head fields stay stable until then, and out_ready may change at any time.
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    // The stage resolves on every edge it is valid, using that cycle's overrun flag.
    assign cancel   = stage_valid && replace_packet_invalid;
    assign commit   = stage_valid && !replace_packet_invalid && (!fifo_full || pop);
    assign overflow = stage_valid && !replace_packet_invalid && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid    <= 1'b0;
            stage_data     <= '0;
            cancel_count   <= '0;
            overflow_count <= '0;
        end else begin
            stage_valid <= replace_internal_valid;
            if (replace_internal_valid) stage_data <= in_event;
            if (cancel && (cancel_count != '1))     cancel_count   <= cancel_count + 1'b1;
            if (overflow && (overflow_count != '1)) overflow_count <= overflow_count + 1'b1;
        end
    end

    itch_sync_fifo #(
        .WIDTH (REPLACE_EVENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (commit),
        .push_data (stage_data),
        .pop       (pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign out_parsed_type   = out_valid ? head.parsed_type : '0;
    assign out_old_order_ref = out_valid ? head.old_ref     : '0;
    assign out_new_order_ref = out_valid ? head.new_ref     : '0;
    assign out_shares        = out_valid ? head.shares      : '0;
    assign out_price         = out_valid ? head.price       : '0;

endmodule

// File: tb/tb_replace_event_queue.sv
// Bench for replace_event_queue: directed scenarios plus random traffic, compared every cycle
// against a queue-based reference model; a second instance with 2-bit counters covers saturation.
module tb_replace_event_queue;
    import itch_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        replace_internal_valid;
    logic        replace_packet_invalid;
    logic [7:0]  replace_parsed_type;
    logic [63:0] replace_old_order_ref;
    logic [63:0] replace_new_order_ref;
    logic [31:0] replace_shares;
    logic [31:0] replace_price;
    logic        out_ready;

    logic        out_valid;
    logic [7:0]  out_parsed_type;
    logic [63:0] out_old_order_ref;
    logic [63:0] out_new_order_ref;
    logic [31:0] out_shares;
    logic [31:0] out_price;
    logic [CW-1:0] fifo_count;
    logic        fifo_full;
    logic [15:0] cancel_count;
    logic [15:0] overflow_count;

    logic        s_out_valid;
    logic [7:0]  s_out_parsed_type;
    logic [63:0] s_out_old_order_ref;
    logic [63:0] s_out_new_order_ref;
    logic [31:0] s_out_shares;
    logic [31:0] s_out_price;
    logic [CW-1:0] s_fifo_count;
    logic        s_fifo_full;
    logic [1:0]  s_cancel_count;
    logic [1:0]  s_overflow_count;

    replace_event_queue #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .replace_internal_valid(replace_internal_valid),
        .replace_packet_invalid(replace_packet_invalid),
        .replace_parsed_type(replace_parsed_type),
        .replace_old_order_ref(replace_old_order_ref),
        .replace_new_order_ref(replace_new_order_ref),
        .replace_shares(replace_shares),
        .replace_price(replace_price),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_parsed_type(out_parsed_type),
        .out_old_order_ref(out_old_order_ref),
        .out_new_order_ref(out_new_order_ref),
        .out_shares(out_shares), .out_price(out_price),
        .fifo_count(fifo_count), .fifo_full(fifo_full),
        .cancel_count(cancel_count), .overflow_count(overflow_count)
    );

    replace_event_queue #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .replace_internal_valid(replace_internal_valid),
        .replace_packet_invalid(replace_packet_invalid),
        .replace_parsed_type(replace_parsed_type),
        .replace_old_order_ref(replace_old_order_ref),
        .replace_new_order_ref(replace_new_order_ref),
        .replace_shares(replace_shares),
        .replace_price(replace_price),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_parsed_type(s_out_parsed_type),
        .out_old_order_ref(s_out_old_order_ref),
        .out_new_order_ref(s_out_new_order_ref),
        .out_shares(s_out_shares), .out_price(s_out_price),
        .fifo_count(s_fifo_count), .fifo_full(s_fifo_full),
        .cancel_count(s_cancel_count), .overflow_count(s_overflow_count)
    );

    // reference model and scoreboard
    logic [REPLACE_EVENT_W-1:0] exp_q[$];
    logic                       m_stage_v;
    logic [REPLACE_EVENT_W-1:0] m_stage_d;
    int                         m_cancels;
    int                         m_overflows;
    int                         checks;
    int                         failures;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [REPLACE_EVENT_W-1:0] head;
        logic                       ev;
        ev   = (exp_q.size() > 0);
        head = ev ? exp_q[0] : '0;
        chk("out_valid", out_valid, ev);
        chk("head", {out_parsed_type, out_old_order_ref, out_new_order_ref, out_shares, out_price}, head);
        chk("fifo_count", fifo_count, exp_q.size());
        chk("fifo_full", fifo_full, exp_q.size() == DEPTH);
        chk("cancel_count", cancel_count, sat(m_cancels, 65535));
        chk("overflow_count", overflow_count, sat(m_overflows, 65535));
        chk("sat_cancel_count", s_cancel_count, sat(m_cancels, 3));
        chk("sat_overflow_count", s_overflow_count, sat(m_overflows, 3));
        chk("sat_head", {s_out_valid, s_out_parsed_type, s_out_old_order_ref, s_out_new_order_ref,
                         s_out_shares, s_out_price}, {ev, head});
    endtask

    // Advance one clock: update the model from the inputs held across the edge, then check.
    task automatic cycle();
        bit pop;
        bit push;
        pop  = (exp_q.size() > 0) && out_ready;
        push = 1'b0;
        if (rst) begin
            exp_q.delete();
            m_stage_v   = 1'b0;
            m_cancels   = 0;
            m_overflows = 0;
        end else begin
            if (m_stage_v) begin
                if (replace_packet_invalid) m_cancels++;
                else if (exp_q.size() < DEPTH || pop) push = 1'b1;
                else m_overflows++;
            end
            if (pop) void'(exp_q.pop_front());
            if (push) exp_q.push_back(m_stage_d);
            m_stage_v = replace_internal_valid;
            if (replace_internal_valid)
                m_stage_d = {replace_parsed_type, replace_old_order_ref, replace_new_order_ref,
                             replace_shares, replace_price};
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    // driver tasks
    task automatic drive_msg(input logic [63:0] old_ref, input logic [63:0] new_ref,
                             input logic [31:0] shares, input logic [31:0] price);
        replace_internal_valid = 1'b1;
        replace_parsed_type    = MSG_TYPE_REPLACE;
        replace_old_order_ref  = old_ref;
        replace_new_order_ref  = new_ref;
        replace_shares         = shares;
        replace_price          = price;
    endtask

    task automatic drive_rand_msg();
        drive_msg({$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom);
    endtask

    task automatic idle(input int n);
        replace_internal_valid = 1'b0;
        replace_packet_invalid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        m_stage_v   = 1'b0;
        m_stage_d   = '0;
        m_cancels   = 0;
        m_overflows = 0;
        rst                    = 1'b1;
        replace_internal_valid = 1'b0;
        replace_packet_invalid = 1'b0;
        replace_parsed_type    = '0;
        replace_old_order_ref  = '0;
        replace_new_order_ref  = '0;
        replace_shares         = '0;
        replace_price          = '0;
        out_ready              = 1'b0;

        // reset state
        cycle();
        cycle();
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_count", fifo_count, 0);
        rst = 1'b0;

        // single message: visible exactly two cycles after the pulse
        out_ready = 1'b1;
        drive_msg(64'h1122334455667788, 64'h99AABBCCDDEEFF00, 32'd100, 32'h00012345);
        cycle();
        chk("lat_T1_idle", out_valid, 1'b0);
        idle(1);
        chk("lat_T2_valid", out_valid, 1'b1);
        chk("lat_T2_old", out_old_order_ref, 64'h1122334455667788);
        chk("lat_T2_price", out_price, 32'h00012345);
        idle(1);
        chk("single_drained", fifo_count, 0);
        idle(2);

        // cancel via trailing overrun
        drive_rand_msg();
        cycle();
        replace_internal_valid = 1'b0;
        replace_packet_invalid = 1'b1;
        cycle();
        idle(3);
        chk("cancel_one", cancel_count, 1);
        chk("cancel_empty", fifo_count, 0);

        // overflow: DEPTH+2 spaced messages with the consumer stalled
        out_ready = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            drive_rand_msg();
            cycle();
            idle(26);
        end
        chk("ovf_full", fifo_full, 1'b1);
        chk("ovf_count", overflow_count, 2);

        // push and pop in the resolve cycle while full
        drive_rand_msg();
        cycle();
        replace_internal_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("fullpp_count", fifo_count, DEPTH);
        chk("fullpp_ovf", overflow_count, 2);
        idle(2);
        out_ready = 1'b1;
        idle(DEPTH + 2);
        chk("drained", out_valid, 1'b0);

        // back-to-back: first cancelled, second delivered
        drive_rand_msg();
        cycle();
        drive_rand_msg();
        replace_packet_invalid = 1'b1;
        cycle();
        replace_internal_valid = 1'b0;
        replace_packet_invalid = 1'b0;
        cycle();
        chk("b2b_cancel", cancel_count, 2);
        chk("b2b_delivered", out_valid, 1'b1);
        idle(3);
        // overrun with nothing staged is ignored
        replace_packet_invalid = 1'b1;
        cycle();
        idle(2);
        chk("stray_invalid", cancel_count, 2);

        // reset mid-operation with three queued and the stage full
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_rand_msg();
            cycle();
        end
        chk("pre_reset_count", fifo_count, 3);
        replace_internal_valid = 1'b0;
        replace_packet_invalid = 1'b1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        replace_packet_invalid = 1'b0;
        chk("post_reset_valid", out_valid, 1'b0);
        chk("post_reset_cancel", cancel_count, 0);
        idle(3);

        // saturation of the narrow counter
        for (int k = 0; k < 5; k++) begin
            drive_rand_msg();
            cycle();
            replace_internal_valid = 1'b0;
            replace_packet_invalid = 1'b1;
            cycle();
            replace_packet_invalid = 1'b0;
        end
        idle(2);
        chk("sat_cancel3", s_cancel_count, 2'd3);
        chk("wide_cancel5", cancel_count, 5);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(1, 0) == 1) drive_rand_msg();
            else replace_internal_valid = 1'b0;
            replace_packet_invalid = ($urandom_range(3, 0) == 0);
            out_ready = ($urandom_range(2, 0) != 0);
            cycle();
        end
        out_ready = 1'b1;
        idle(DEPTH + 4);
        chk("final_empty", fifo_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
